result_sender: RTL and testbench

Transmits a completed result vector off-chip while the top-level controller is in its sending phase. A `start` pulse triggers the transfer. The block then reads `num_words` result words from the result memory and serializes each one into `OUT_WIDTH`-bit chunks over a valid/ready output port. When the last chunk has been accepted, it pulses `done`, which drives the controller's `done_sending` input.

---
 rtl/sender_pkg.sv | 36 +++
 rtl/word_serializer.sv | 58 +++++
 rtl/result_sender.sv | 150 +++++++++++++++
 tb/tb_result_sender.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sender_pkg.sv
// Shared definitions for result_sender: FSM encoding, chunk-count helpers
// and a parameter-legality check macro.
// RESULT_SENDER_CHECKSUM_EN adds the CHECK state used for the trailing XOR checksum word.
`ifndef SENDER_PKG_SV
`define SENDER_PKG_SV

// Elaboration-time legality check. Expand inside a module body.
`define SENDER_CHECK_PARAMS(ww, ow, mw) if ((ow) < 1 || (ww) < (ow) || ((ww) % (ow)) != 0 || (mw) < 2) begin : g_bad_params $error("result_sender: WORD_WIDTH must be a multiple of OUT_WIDTH and MAX_WORDS >= 2"); end

package sender_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
`ifdef RESULT_SENDER_CHECKSUM_EN
    ST_CHECK = 3'd4,
`endif
    ST_DONE  = 3'd5
  } state_t;

  localparam int DEF_WORD_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH   = 4;
  localparam int CHUNKS_PER_WORD = DEF_WORD_WIDTH / DEF_OUT_WIDTH;

  // Chunk count for non-default widths.
  function automatic int chunks_per_word(input int ww, input int ow);
    return ww / ow;
  endfunction

endpackage

`endif

// File: rtl/word_serializer.sv
// Load/shift register that emits one word as MSB-first chunks over valid/ready.
// out_valid is derived from the chunk counter, so it can only fall after a
// handshake on the final chunk.
module word_serializer
  import sender_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int OUT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_data,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  output logic                  last_chunk,
  output logic                  beat
);

  localparam int CPW   = chunks_per_word(WORD_WIDTH, OUT_WIDTH);
  localparam int CNT_W = $clog2(CPW + 1);

  `SENDER_CHECK_PARAMS(WORD_WIDTH, OUT_WIDTH, 2)

  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign out_valid  = (cnt_q != '0);
  assign beat       = out_valid & out_ready;
  assign last_chunk = (cnt_q == CNT_W'(1));
  assign out_data   = shreg_q[WORD_WIDTH-1 -: OUT_WIDTH];

  // Load wins over shift so a new word can be queued on the final beat.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = load_data;
      cnt_d   = CNT_W'(CPW);
    end else if (beat) begin
      shreg_d = shreg_q << OUT_WIDTH;
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  // Shift register and chunk counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/result_sender.sv
// Reads num_words result words from memory and streams them off-chip as
// OUT_WIDTH chunks, then pulses done.
// RESULT_SENDER_CHECKSUM_EN appends the XOR of all words as one extra word.
module result_sender
  import sender_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int OUT_WIDTH  = 4,
  parameter int MAX_WORDS  = 64,
  parameter int ADDR_WIDTH = $clog2(MAX_WORDS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(MAX_WORDS+1)-1:0] num_words,
  output logic                           rd_en,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic [WORD_WIDTH-1:0]          rd_data,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done
);

  localparam int CNT_WIDTH = $clog2(MAX_WORDS + 1);

  `SENDER_CHECK_PARAMS(WORD_WIDTH, OUT_WIDTH, MAX_WORDS)

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  left_q, left_d;
`ifdef RESULT_SENDER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] csum_q, csum_d;
`endif

  logic                  ser_load;
  logic [WORD_WIDTH-1:0] ser_data;
  logic                  ser_last;
  logic                  ser_beat;

  word_serializer #(
    .WORD_WIDTH (WORD_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .load_data  (ser_data),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .last_chunk (ser_last),
    .beat       (ser_beat)
  );

  assign rd_en   = (state_q == ST_FETCH);
  assign rd_addr = idx_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

  // Next-state, word bookkeeping and serializer load control.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    left_d   = left_q;
    ser_load = 1'b0;
    ser_data = rd_data;
`ifdef RESULT_SENDER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d  = '0;
          left_d = (num_words > CNT_WIDTH'(MAX_WORDS)) ? CNT_WIDTH'(MAX_WORDS) : num_words;
`ifdef RESULT_SENDER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (num_words != '0) begin
            state_d = ST_FETCH;
          end else begin
`ifdef RESULT_SENDER_CHECKSUM_EN
            // Empty transfer still carries the all-zero checksum word.
            state_d  = ST_CHECK;
            ser_load = 1'b1;
            ser_data = '0;
`else
            state_d  = ST_DONE;
`endif
          end
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        ser_load = 1'b1;
        ser_data = rd_data;
`ifdef RESULT_SENDER_CHECKSUM_EN
        csum_d   = csum_q ^ rd_data;
`endif
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ser_beat && ser_last) begin
          idx_d  = (idx_q == ADDR_WIDTH'(MAX_WORDS - 1)) ? '0 : idx_q + ADDR_WIDTH'(1);
          left_d = left_q - CNT_WIDTH'(1);
          if (left_q == CNT_WIDTH'(1)) begin
`ifdef RESULT_SENDER_CHECKSUM_EN
            // Checksum is final here: the last word was folded in during WAIT.
            state_d  = ST_CHECK;
            ser_load = 1'b1;
            ser_data = csum_q;
`else
            state_d  = ST_DONE;
`endif
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
`ifdef RESULT_SENDER_CHECKSUM_EN
      ST_CHECK: begin
        if (ser_beat && ser_last) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset abandons any transfer without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      left_q  <= '0;
`ifdef RESULT_SENDER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
`ifdef RESULT_SENDER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_result_sender.sv
// Scoreboard bench for result_sender: expected chunks and read addresses are
// queued at stimulus time and consumed by an independent negedge monitor.
`timescale 1ns/1ps
module tb_result_sender;

  localparam int WW  = 16;
  localparam int OW  = 4;
  localparam int MW  = 64;
  localparam int AW  = 6;
  localparam int NW  = 7;
  localparam int CPW = 4;
`ifdef RESULT_SENDER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] num_words;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_data;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  result_sender #(.WORD_WIDTH(WW), .OUT_WIDTH(OW), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Result memory model: one-cycle registered read.
  logic [WW-1:0] mem [MW];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  int beats, done_count, done_cyc, last_beat_cyc, first_rd_cyc, first_valid_cyc, s_cyc;
  bit ready_mode = 1'b0;
  logic [3:0] ready_pat = 4'b1001;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [OW-1:0] prev_data = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Receiver ready: tied high or repeating 1-0-0-1.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_mode ? ready_pat[cyc % 4] : 1'b1;
    end
  end

  // Monitor: consumes the scoreboard and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      if (rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        check("rd_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("rd_addr", rd_addr, addr_q.pop_front());
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        beats++;
        last_beat_cyc = cyc;
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  task automatic clear_stats();
    beats = 0; done_count = 0; done_cyc = -1; last_beat_cyc = -1;
    first_rd_cyc = -1; first_valid_cyc = -1;
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    for (int k = CPW - 1; k >= 0; k--) exp_q.push_back(w[k*OW +: OW]);
  endtask

  task automatic start_xfer(input int n);
    clear_stats();
    @(posedge clk); #1;
    num_words = NW'(n);
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_count == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("done_seen", done_count != 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic finish_checks(input int exp_beats, input int exp_reads, input int done_off);
    check("done_count", done_count, 1);
    check("beats", beats, exp_beats);
    check("chunks_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
    check("busy_end", busy, 0);
    if (exp_beats > 0) check("done_after_beat", done_cyc, last_beat_cyc + 1);
    if (exp_reads > 0) begin
      check("rd_latency", first_rd_cyc, s_cyc + 1);
      check("valid_latency", first_valid_cyc, s_cyc + 3);
    end
    if (done_off > 0) check("done_time", done_cyc, s_cyc + done_off);
  endtask

  initial begin
    logic [WW-1:0] acc;
    int k;
    rst = 1'b1; start = 1'b0; num_words = '0; rd_data = '0;
    for (int i = 0; i < MW; i++) mem[i] = '0;
    clear_stats();
    #2;
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Two words, ready tied high.
    mem[0] = 16'hABCD; mem[1] = 16'h1234;
    exp_q = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
    if (CS != 0) begin
      exp_q.push_back(4'hB); exp_q.push_back(4'h9); exp_q.push_back(4'hF); exp_q.push_back(4'h9);
    end
    addr_q = '{6'd0, 6'd1};
    start_xfer(2);
    wait_done(200);
    finish_checks(8 + 4*CS, 2, 13 + 4*CS);
    $display("xfer two_words beats=%0d done_cyc=%0d", beats, done_cyc - s_cyc);

    // Same words, ready toggling 1-0-0-1.
    ready_mode = 1'b1;
    exp_q = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
    if (CS != 0) begin
      exp_q.push_back(4'hB); exp_q.push_back(4'h9); exp_q.push_back(4'hF); exp_q.push_back(4'h9);
    end
    addr_q = '{6'd0, 6'd1};
    start_xfer(2);
    wait_done(400);
    finish_checks(8 + 4*CS, 2, 0);
    $display("xfer stalled beats=%0d done_cyc=%0d", beats, done_cyc - s_cyc);
    ready_mode = 1'b0;
    @(posedge clk); #2;

    // Empty transfer.
    if (CS != 0) begin
      exp_q = '{4'h0, 4'h0, 4'h0, 4'h0};
    end
    start_xfer(0);
    wait_done(50);
    finish_checks(4*CS, 0, 1 + 4*CS);
    $display("xfer empty beats=%0d done_cyc=%0d", beats, done_cyc - s_cyc);

    // Restart attempt while word 1 of 3 is in flight.
    mem[0] = 16'h0F1E; mem[1] = 16'h2D3C; mem[2] = 16'h4B5A;
    push_word(16'h0F1E); push_word(16'h2D3C); push_word(16'h4B5A);
    if (CS != 0) begin
      exp_q.push_back(4'h6); exp_q.push_back(4'h9); exp_q.push_back(4'h7); exp_q.push_back(4'h8);
    end
    addr_q = '{6'd0, 6'd1, 6'd2};
    start_xfer(3);
    k = 0;
    while (!(rd_en && rd_addr == 6'd1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("saw_word1_fetch", k < 50, 1);
    @(posedge clk); #1;
    num_words = NW'(5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    finish_checks(12 + 4*CS, 3, 19 + 4*CS);
    $display("xfer restart_ignored beats=%0d done_cyc=%0d", beats, done_cyc - s_cyc);

    // Reset during the SHIFT of word 1, then a clean transfer.
    mem[0] = 16'hABCD; mem[1] = 16'h1234;
    push_word(16'hABCD); push_word(16'h1234);
    addr_q = '{6'd0, 6'd1};
    start_xfer(2);
    k = 0;
    while (!(out_valid && rd_addr == 6'd1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("saw_word1_shift", k < 50, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rd_en", rd_en, 0);
    check("arst_rd_addr", rd_addr, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_no_done", done_count, 0);
    $display("xfer reset_abort beats_before_reset=%0d", beats);
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    rst = 1'b0;
    push_word(16'hABCD); push_word(16'h1234);
    if (CS != 0) push_word(16'hB9F9);
    addr_q = '{6'd0, 6'd1};
    start_xfer(2);
    wait_done(200);
    finish_checks(8 + 4*CS, 2, 13 + 4*CS);
    $display("xfer after_reset beats=%0d done_cyc=%0d", beats, done_cyc - s_cyc);

    // Full-depth transfer, then an over-range count clamped to MAX_WORDS.
    for (int pass = 0; pass < 2; pass++) begin
      acc = '0;
      for (int i = 0; i < MW; i++) begin
        mem[i] = {4'(i % 16), 4'(15 - (i % 16)), 8'(i * 3 + pass)};
        acc = acc ^ mem[i];
        push_word(mem[i]);
        addr_q.push_back(AW'(i));
      end
      if (CS != 0) push_word(acc);
      start_xfer(pass == 0 ? 64 : 100);
      wait_done(2000);
      finish_checks(256 + 4*CS, 64, 6*64 + 1 + 4*CS);
      $display("xfer full_depth n=%0d beats=%0d done_cyc=%0d", pass == 0 ? 64 : 100, beats, done_cyc - s_cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
